// File: rtl/vend_fsm_if.sv
// Vending controller bus: customer-side inputs and display/actuator outputs.
// master = customer panel / test driver, slave = vend_fsm.
interface vend_fsm_if;
  logic [2:0] coins_i;
  logic [2:0] goods_i;
  logic       done_i;
  logic       confirm_i;
  logic       cancel_i;
  logic [7:0] credit_o;
  logic [7:0] price_o;
  logic [7:0] change_o;
  logic       dispense_o;
  logic [2:0] item_o;
  logic       coin_reject_o;
  logic       err_short_o;
  logic       busy_o;
  logic [2:0] state_o;

  modport master (
    output coins_i, goods_i, done_i, confirm_i, cancel_i,
    input  credit_o, price_o, change_o, dispense_o, item_o,
           coin_reject_o, err_short_o, busy_o, state_o
  );

  modport slave (
    input  coins_i, goods_i, done_i, confirm_i, cancel_i,
    output credit_o, price_o, change_o, dispense_o, item_o,
           coin_reject_o, err_short_o, busy_o, state_o
  );
endinterface

// File: rtl/vend_fsm.sv
// Coin-operated vending controller: collects credit, vends against a fixed
// price table, returns change/refunds, and auto-refunds an idle customer.
// All outputs are registered; inputs affect outputs one cycle later.
module vend_fsm #(
  parameter int CREDIT_MAX = 99,
  parameter int TIMEOUT    = 500000000
) (
  input logic       clk_i,
  input logic       rst_i,
  vend_fsm_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_VEND    = 3'd2,
    S_CHANGE  = 3'd3,
    S_REFUND  = 3'd4
  } state_e;

  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);
  localparam logic [8:0]  CMAX9    = 9'(CREDIT_MAX);

  function automatic logic [7:0] price_of(input logic [2:0] g);
    case (g)
      3'd0:    return 8'd3;
      3'd1:    return 8'd5;
      3'd2:    return 8'd7;
      3'd3:    return 8'd10;
      3'd4:    return 8'd12;
      3'd5:    return 8'd15;
      3'd6:    return 8'd20;
      default: return 8'd25;
    endcase
  endfunction

  state_e      state_q;
  logic [7:0]  credit_q, price_q, change_q;
  logic [2:0]  item_q;
  logic        dispense_q, reject_q, short_q, busy_q;
  logic [31:0] tmo_q;

  logic [4:0] coin_val;
  logic [8:0] sum9;
  logic       over;
  logic       coin_any;
  logic [7:0] acc;      // credit after this cycle's coins (unchanged if refused)
  logic [7:0] sel_price;
  logic       any_cmd;

  assign coin_val  = (bus.coins_i[0] ? 5'd1  : 5'd0)
                   + (bus.coins_i[1] ? 5'd5  : 5'd0)
                   + (bus.coins_i[2] ? 5'd10 : 5'd0);
  assign sum9      = {1'b0, credit_q} + {4'b0, coin_val};
  assign over      = sum9 > CMAX9;
  assign coin_any  = |bus.coins_i;
  assign acc       = over ? credit_q : sum9[7:0];
  assign sel_price = price_of(bus.goods_i);
  assign any_cmd   = coin_any | bus.confirm_i | bus.cancel_i;

  // Controller state, datapath registers and one-cycle pulse outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      credit_q   <= 8'd0;
      price_q    <= 8'd0;
      change_q   <= 8'd0;
      item_q     <= 3'd0;
      dispense_q <= 1'b0;
      reject_q   <= 1'b0;
      short_q    <= 1'b0;
      busy_q     <= 1'b0;
      tmo_q      <= 32'd0;
    end else begin
      price_q    <= sel_price;
      dispense_q <= 1'b0;
      reject_q   <= 1'b0;
      short_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (coin_any) begin
            if (over) begin
              reject_q <= 1'b1;
            end else begin
              credit_q <= acc;
              tmo_q    <= 32'd0;
              state_q  <= S_COLLECT;
            end
          end
        end
        S_COLLECT: begin
          // Any customer activity restarts the idle-refund count.
          if (any_cmd)                tmo_q <= 32'd0;
          else if (tmo_q != TMO_LAST) tmo_q <= tmo_q + 32'd1;
          if (coin_any && over) reject_q <= 1'b1;
          if (bus.cancel_i) begin
            change_q <= acc;
            credit_q <= 8'd0;
            busy_q   <= 1'b1;
            state_q  <= S_REFUND;
          end else if (bus.confirm_i) begin
            if (acc >= sel_price) begin
              item_q     <= bus.goods_i;
              change_q   <= acc - sel_price;
              credit_q   <= 8'd0;
              dispense_q <= 1'b1;
              busy_q     <= 1'b1;
              state_q    <= S_VEND;
            end else begin
              credit_q <= acc;
              short_q  <= 1'b1;
            end
          end else if (coin_any) begin
            credit_q <= acc;
          end else if (tmo_q == TMO_LAST) begin
            change_q <= credit_q;
            credit_q <= 8'd0;
            busy_q   <= 1'b1;
            state_q  <= S_REFUND;
          end
        end
        S_VEND: begin
          if (coin_any) reject_q <= 1'b1;
          state_q <= S_CHANGE;
        end
        S_CHANGE, S_REFUND: begin
          if (coin_any) reject_q <= 1'b1;
          if (bus.done_i) begin
            change_q <= 8'd0;
            item_q   <= 3'd0;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.credit_o      = credit_q;
  assign bus.price_o       = price_q;
  assign bus.change_o      = change_q;
  assign bus.dispense_o    = dispense_q;
  assign bus.item_o        = item_q;
  assign bus.coin_reject_o = reject_q;
  assign bus.err_short_o   = short_q;
  assign bus.busy_o        = busy_q;
  assign bus.state_o       = state_q;
endmodule

// File: tb/tb_vend_fsm.sv
// Directed bench for vend_fsm: a customer-level model tracks what the
// machine owes and displays; every cycle the DUT is compared against it,
// and hand-computed literals pin the scenarios.
module tb_vend_fsm;
  localparam int CMAX = 99;
  localparam int TMO  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] g = 3'd0;
  always #5 clk = ~clk;

  vend_fsm_if bus();
  vend_fsm #(.CREDIT_MAX(CMAX), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );

  int n_tot = 0, n_pass = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s @%0t: got %0d, want %0d", nm, $time, act, exp);
  endtask

  // ---------------- customer-level model ----------------
  // Phases use the externally visible codes: 0 idle, 1 collecting,
  // 2 vending, 3 paying change, 4 refunding.
  int PRICES[8] = '{3, 5, 7, 10, 12, 15, 20, 25};
  int m_ph = 0, m_credit = 0, m_price = 0, m_owed = 0, m_item = 0, m_quiet = 0;
  bit m_disp = 0, m_rej = 0, m_short = 0;

  int  w, pool, ph, cr, ow, it, qt;
  bit  rj, sh, dp;

  always @(posedge clk) begin
    ph = m_ph; cr = m_credit; ow = m_owed; it = m_item; qt = m_quiet;
    rj = 0; sh = 0; dp = 0;
    if (rst) begin
      ph = 0; cr = 0; ow = 0; it = 0; qt = 0;
    end else begin
      w = (bus.coins_i[0] ? 1 : 0) + (bus.coins_i[1] ? 5 : 0) + (bus.coins_i[2] ? 10 : 0);
      if (ph >= 2) begin
        // Machine is serving: coins bounce, only 'done' matters (not while vending).
        if (w != 0) rj = 1;
        if (ph == 2) ph = 3;
        else if (bus.done_i) begin ph = 0; ow = 0; it = 0; end
      end else begin
        if (w != 0 && cr + w > CMAX) rj = 1;
        pool = rj ? cr : cr + w;
        if (ph == 0) begin
          if (w != 0 && !rj) begin cr = pool; ph = 1; qt = 0; end
        end else if (bus.cancel_i) begin
          ow = pool; cr = 0; ph = 4;
        end else if (bus.confirm_i) begin
          if (pool >= PRICES[bus.goods_i]) begin
            ow = pool - PRICES[bus.goods_i]; cr = 0; it = bus.goods_i; dp = 1; ph = 2;
          end else begin
            cr = pool; sh = 1;
          end
          qt = 0;
        end else if (w != 0) begin
          cr = pool; qt = 0;
        end else begin
          qt = qt + 1;
          if (qt == TMO) begin ow = cr; cr = 0; ph = 4; end
        end
      end
    end
    m_ph <= ph; m_credit <= cr; m_owed <= ow; m_item <= it; m_quiet <= qt;
    m_disp <= dp; m_rej <= rj; m_short <= sh;
    m_price <= rst ? 0 : PRICES[bus.goods_i];
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("credit",   bus.credit_o,      m_credit);
      chk("price",    bus.price_o,       m_price);
      chk("change",   bus.change_o,      m_owed);
      chk("dispense", bus.dispense_o,    m_disp);
      chk("item",     bus.item_o,        m_item);
      chk("reject",   bus.coin_reject_o, m_rej);
      chk("short",    bus.err_short_o,   m_short);
      chk("busy",     bus.busy_o,        (m_ph >= 2) ? 1 : 0);
      chk("state",    bus.state_o,       m_ph);
    end
  end

  // One clock of stimulus; returns at the negedge after the edge consumed it.
  task automatic drive(input logic [2:0] c, input logic cf, input logic cn, input logic dn);
    bus.coins_i   = c;
    bus.confirm_i = cf;
    bus.cancel_i  = cn;
    bus.done_i    = dn;
    bus.goods_i   = g;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(3'b000, 0, 0, 0);
  endtask

  initial begin
    bus.coins_i = 0; bus.goods_i = 0; bus.confirm_i = 0; bus.cancel_i = 0; bus.done_i = 0;
    @(negedge clk);
    idle(1);
    chk_en = 1;
    idle(1);
    chk("rst.state", bus.state_o, 0);
    chk("rst.credit", bus.credit_o, 0);
    rst = 0;

    // Basic purchase: 10+5+1, item 3 (price 10), change 6.
    g = 3;
    drive(3'b100, 0, 0, 0);
    chk("buy.price_reload", bus.price_o, 10);
    chk("buy.credit10", bus.credit_o, 10);
    drive(3'b010, 0, 0, 0);
    drive(3'b001, 0, 0, 0);
    chk("buy.credit16", bus.credit_o, 16);
    drive(3'b000, 1, 0, 0);
    chk("buy.dispense", bus.dispense_o, 1);
    chk("buy.item", bus.item_o, 3);
    chk("buy.change", bus.change_o, 6);
    chk("buy.state_vend", bus.state_o, 2);
    g = 5;                               // late goods change, done during VEND
    drive(3'b000, 0, 0, 1);
    chk("buy.state_change", bus.state_o, 3);
    chk("buy.item_held", bus.item_o, 3);
    chk("buy.dispense_off", bus.dispense_o, 0);
    drive(3'b000, 0, 0, 1);
    chk("buy.idle", bus.state_o, 0);
    chk("buy.change0", bus.change_o, 0);

    // Short credit: 3 against price 20, then 10+confirm -> 13 still short.
    g = 6;
    drive(3'b001, 0, 0, 0); drive(3'b001, 0, 0, 0); drive(3'b001, 0, 0, 0);
    drive(3'b000, 1, 0, 0);
    chk("short.pulse", bus.err_short_o, 1);
    chk("short.credit3", bus.credit_o, 3);
    idle(1);
    chk("short.width", bus.err_short_o, 0);
    drive(3'b100, 1, 0, 0);
    chk("short.again", bus.err_short_o, 1);
    chk("short.credit13", bus.credit_o, 13);
    drive(3'b000, 0, 1, 0);
    chk("short.refund", bus.change_o, 13);
    drive(3'b000, 0, 0, 1);

    // Overflow: 95, then 5 and 1+5 refused.
    for (int i = 0; i < 9; i++) drive(3'b100, 0, 0, 0);
    drive(3'b010, 0, 0, 0);
    chk("ovf.credit95", bus.credit_o, 95);
    drive(3'b010, 0, 0, 0);
    chk("ovf.reject5", bus.coin_reject_o, 1);
    drive(3'b011, 0, 0, 0);
    chk("ovf.reject6", bus.coin_reject_o, 1);
    chk("ovf.credit_held", bus.credit_o, 95);
    idle(1);
    g = 0;
    drive(3'b000, 1, 1, 0);               // cancel wins over confirm
    chk("prio.refund", bus.state_o, 4);
    chk("prio.change", bus.change_o, 95);
    drive(3'b000, 0, 0, 1);

    // Cancel with a coin in the same cycle: credit 7 -> refund 8.
    drive(3'b010, 0, 0, 0); drive(3'b001, 0, 0, 0); drive(3'b001, 0, 0, 0);
    drive(3'b001, 0, 1, 0);
    chk("cancel.change8", bus.change_o, 8);
    chk("cancel.credit0", bus.credit_o, 0);
    drive(3'b100, 0, 0, 0);
    chk("cancel.reject", bus.coin_reject_o, 1);
    drive(3'b000, 1, 1, 0);
    chk("cancel.ignored", bus.state_o, 4);
    drive(3'b000, 0, 0, 1);
    chk("cancel.idle", bus.state_o, 0);

    // Exact payment, coin during VEND refused.
    drive(3'b001, 0, 0, 0); drive(3'b001, 0, 0, 0); drive(3'b001, 0, 0, 0);
    drive(3'b000, 1, 0, 0);
    chk("exact.change0", bus.change_o, 0);
    drive(3'b100, 0, 0, 0);
    chk("vendcoin.reject", bus.coin_reject_o, 1);
    drive(3'b000, 0, 0, 1);

    // Timeout: credit 5, 8th quiet cycle refunds.
    drive(3'b010, 0, 0, 0);
    idle(7);
    chk("tmo.still_collect", bus.state_o, 1);
    idle(1);
    chk("tmo.refund", bus.state_o, 4);
    chk("tmo.change5", bus.change_o, 5);
    drive(3'b000, 0, 0, 1);

    // Timeout restart: coin after 3 quiet cycles restarts the count.
    drive(3'b010, 0, 0, 0);
    idle(3);
    drive(3'b001, 0, 0, 0);
    idle(7);
    chk("tmo2.still_collect", bus.state_o, 1);
    idle(1);
    chk("tmo2.refund", bus.state_o, 4);
    chk("tmo2.change6", bus.change_o, 6);
    drive(3'b000, 0, 0, 1);

    // Reset during CHANGE discards everything.
    g = 3;
    drive(3'b100, 0, 0, 0); drive(3'b010, 0, 0, 0); drive(3'b001, 0, 0, 0);
    drive(3'b000, 1, 0, 0);
    idle(1);
    chk("rstchg.change6", bus.change_o, 6);
    rst = 1;
    idle(1);
    chk("rstchg.state", bus.state_o, 0);
    chk("rstchg.change", bus.change_o, 0);
    chk("rstchg.busy", bus.busy_o, 0);
    chk("rstchg.price", bus.price_o, 0);
    rst = 0;
    g = 7;
    idle(1);
    chk("rstchg.price_reload", bus.price_o, 25);
    chk("rstchg.no_refund", bus.change_o, 0);
    idle(2);

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/vend_fsm.md
VEND_FSM -- requirements
Module: vend_fsm

Interface
REQ-001 Parameter CREDIT_MAX, default 99: max credit units accepted; a coin pushing credit above it is rejected.
REQ-002 Parameter TIMEOUT, default 500000000: idle cycles in COLLECT before auto-refund; 32-bit counter.
REQ-003 clk  in  1  system clock, single domain.
REQ-004 rst  in  1  synchronous reset, active-high.
REQ-005 coins  in  3  single-cycle debounced coin pulses: bit0=1 unit, bit1=5 units, bit2=10 units.
REQ-006 goods  in  3  item select, level; price table 0..7 = 3,5,7,10,12,15,20,25 units.
REQ-007 done  in  1  single-cycle pulse: customer has collected item/change.
REQ-008 confirm  in  1  single-cycle purchase request pulse.
REQ-009 cancel  in  1  single-cycle refund request pulse.
REQ-010 credit  out  8  current accumulated credit, registered.
REQ-011 price  out  8  price of the current goods selection, registered one cycle after goods.
REQ-012 change  out  8  change/refund amount owed, registered.
REQ-013 dispense  out  1  one-cycle pulse releasing the item.
REQ-014 item  out  3  goods index latched at confirm; valid while dispense=1 and through CHANGE.
REQ-015 coin_reject  out  1  one-cycle pulse when a coin is refused.
REQ-016 err_short  out  1  one-cycle pulse when confirm arrives with insufficient credit.
REQ-017 busy  out  1  high in VEND, CHANGE, REFUND (LED drive).
REQ-018 state  out  3  encoded state: IDLE=0, COLLECT=1, VEND=2, CHANGE=3, REFUND=4.

Function
REQ-019 Coin value per cycle = sum of all asserted coins bits (0..16); credit_next = credit + value, computed 9-bit.
REQ-020 IDLE: credit=0, change=0; nonzero accepted coin -> COLLECT with credit=value; confirm/cancel/done ignored.
REQ-021 COLLECT/IDLE: if credit_next > CREDIT_MAX, whole cycle's coins rejected, credit unchanged, coin_reject=1 next cycle.
REQ-022 COLLECT priority: cancel > confirm > coin-only; coins in the same cycle are accepted first, then the command uses credit_next.
REQ-023 COLLECT, cancel: -> REFUND, change = credit_next, credit = 0.
REQ-024 COLLECT, confirm with credit_next >= price[goods]: -> VEND, item = goods, change = credit_next - price, credit = 0.
REQ-025 COLLECT, confirm with credit_next < price[goods]: stay, credit = credit_next, err_short=1 next cycle.
REQ-026 COLLECT timeout: counter clears on any coin/confirm/cancel input; at TIMEOUT-1 with no input -> REFUND, change = credit.
REQ-027 VEND: lasts exactly one cycle, dispense=1; -> CHANGE.
REQ-028 CHANGE and REFUND: hold change; done -> IDLE, change=0, item=0; done before entering is ignored.
REQ-029 Coins arriving in VEND, CHANGE or REFUND are refused: coin_reject=1 next cycle, no credit change.
REQ-030 confirm/cancel in VEND, CHANGE, REFUND are ignored; goods changes after confirm do not alter item or change.
REQ-031 Latency: input pulse at cycle N -> registered outputs and state updated at N+1; no combinational input-to-output paths.
REQ-032 Pulse outputs (dispense, coin_reject, err_short) are exactly one cycle wide, never stretched.

Reset
REQ-033 rst=1 at any clock edge, including mid-VEND/CHANGE/REFUND: state=IDLE; credit, change, item, all pulses, busy, timeout counter = 0; price reloads on the first cycle after release.
REQ-034 Credit held at reset is discarded; no refund is generated.

Verification
REQ-035 Coins 10,5,1 then goods=3, confirm -> credit 16; dispense pulse, item=3, change=6, state CHANGE; done -> IDLE, change=0.
REQ-036 credit 3, goods=6, confirm -> err_short one cycle, state COLLECT, credit 3; coin 10 + confirm same cycle -> credit_next 13 < 20 -> err_short again, credit 13.
REQ-037 credit 95, coin 5 -> coin_reject, credit 95; coin 1+5 same cycle -> rejected together (101 > 99).
REQ-038 credit 7, cancel + coin 1 same cycle -> REFUND, change=8, credit=0; coin in REFUND -> coin_reject; done -> IDLE.
REQ-039 TIMEOUT=8, credit 5, no inputs -> REFUND at 8th idle cycle, change=5; coin at cycle 4 restarts count.
REQ-040 rst asserted during CHANGE with change=6 -> next cycle IDLE, all outputs 0, busy=0.
